// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and types for the FIR MAC sequencer.
//   A_W     - MAC operand A (coefficient) width
//   B_W     - MAC operand B (sample) width
//   ACC_W   - MAC accumulator width
//   Y_W     - narrowed result width
//   MAC_LAT - cycles from operands at the MAC inputs to the product being
//             visible in the accumulator output
//   state_t - sequencer FSM states
package fir_pkg;

    localparam int A_W     = 18;
    localparam int B_W     = 36;
    localparam int ACC_W   = 68;
    localparam int Y_W     = 36;
    localparam int MAC_LAT = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/fir_out_scale.sv
// fir_out_scale: combinational output scaler for the FIR MAC sequencer.
// Arithmetic right shift of the raw accumulator by SHIFT, then narrowing
// to Y_W bits.
// Build option: FIR_SEQ_SAT_EN -- when defined the shifted value is clamped
// to the signed Y_W range; otherwise the low Y_W bits are taken (wrapping).
// Ports:
//   acc  in  ACC_W  raw accumulator value (two's complement)
//   y    out Y_W    scaled, narrowed result
module fir_out_scale
    import fir_pkg::*;
#(
    parameter int SHIFT = 17
)(
    input  logic [ACC_W-1:0] acc,
    output logic [Y_W-1:0]   y
);

    logic signed [ACC_W-1:0] t;

    assign t = $signed(acc) >>> SHIFT;

`ifdef FIR_SEQ_SAT_EN
    logic pos_ovf;
    logic neg_ovf;

    // t fits in Y_W signed bits only when bits [ACC_W-1:Y_W-1] all equal
    // the sign bit.
    assign pos_ovf = !t[ACC_W-1] && (|t[ACC_W-2:Y_W-1]);
    assign neg_ovf =  t[ACC_W-1] && !(&t[ACC_W-2:Y_W-1]);

    always_comb begin
        y = t[Y_W-1:0];
        if (pos_ovf) begin
            y = {1'b0, {(Y_W-1){1'b1}}};
        end else if (neg_ovf) begin
            y = {1'b1, {(Y_W-1){1'b0}}};
        end
    end
`else
    // Upper bits are intentionally discarded in the wrapping build.
    logic unused_hi;
    assign unused_hi = ^t[ACC_W-1:Y_W];
    assign y         = t[Y_W-1:0];
`endif

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: control-side initiator for an external 18x36 pipelined
// MAC. Holds a circular sample delay line and a coefficient bank; for each
// accepted sample it clears the MAC, streams NTAPS coefficient/sample pairs,
// drains the MAC pipeline and presents the scaled result.
// Build option: FIR_SEQ_SAT_EN (see fir_out_scale) selects saturation of
// y_data; y_full is always the raw accumulator.
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   s_valid/s_ready/s_data  sample input handshake (36-bit signed)
//   coef_we/coef_addr/coef_data  coefficient write (honoured in IDLE only)
//   mac_rst, mac_a, mac_b  registered MAC controls/operands
//   mac_out               MAC accumulator output
//   y_valid/y_ready       result handshake
//   y_data                scaled, narrowed result
//   y_full                raw accumulator captured with y_data
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS = 16,
    parameter int SHIFT = 17
)(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [B_W-1:0]           s_data,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [A_W-1:0]           coef_data,
    output logic                     mac_rst,
    output logic [A_W-1:0]           mac_a,
    output logic [B_W-1:0]           mac_b,
    input  logic [ACC_W-1:0]         mac_out,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic [Y_W-1:0]           y_data,
    output logic [ACC_W-1:0]         y_full
);

    localparam int AW    = $clog2(NTAPS);
    // One counter serves both the tap index and the drain count.
    localparam int CNT_W = $clog2(NTAPS + MAC_LAT);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [AW-1:0]    wr_ptr_reg;

    logic [B_W-1:0]   delay_reg [NTAPS];
    logic [A_W-1:0]   coef_reg  [NTAPS];
    logic [NTAPS-1:0] delay_we;
    logic [NTAPS-1:0] coef_wr_en;

    logic             mac_rst_reg, mac_rst_next;
    logic [A_W-1:0]   mac_a_reg, mac_a_next;
    logic [B_W-1:0]   mac_b_reg, mac_b_next;
    logic [Y_W-1:0]   y_data_reg;
    logic [ACC_W-1:0] y_full_reg;
    logic [Y_W-1:0]   scaled;

    logic             accept;
    logic             coef_wr;
    logic             capture;
    logic [AW-1:0]    tap_idx;
    logic [AW-1:0]    rd_idx;

    assign accept  = (state_reg == IDLE) && s_valid;
    assign coef_wr = (state_reg == IDLE) && coef_we;
    // The last drain cycle is the first one in which the final product has
    // reached the accumulator.
    assign capture = (state_reg == DRAIN) && (cnt_reg == CNT_W'(MAC_LAT - 1));

    // Per-entry write enables for the delay line and coefficient bank.
    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_we
            assign delay_we[gi]   = accept  && (wr_ptr_reg == AW'(gi));
            assign coef_wr_en[gi] = coef_wr && (coef_addr  == AW'(gi));
        end
    endgenerate

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (s_valid) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = RUN;
                cnt_next   = '0;
            end
            RUN: begin
                if (cnt_reg == CNT_W'(NTAPS - 1)) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_reg == CNT_W'(MAC_LAT - 1)) begin
                    state_next = OUT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            OUT: begin
                if (y_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // MAC drive values for the next cycle. By the time RUN is entered the
    // write pointer has already advanced past the newest sample, hence the -1.
    assign tap_idx = cnt_next[AW-1:0];
    assign rd_idx  = wr_ptr_reg - AW'(1) - tap_idx;

    always_comb begin
        mac_rst_next = (state_next == CLEAR);
        mac_a_next   = '0;
        mac_b_next   = '0;
        if (state_next == RUN) begin
            mac_a_next = coef_reg[tap_idx];
            mac_b_next = delay_reg[rd_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            wr_ptr_reg  <= '0;
            mac_rst_reg <= 1'b1;
            mac_a_reg   <= '0;
            mac_b_reg   <= '0;
            y_data_reg  <= '0;
            y_full_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mac_rst_reg <= mac_rst_next;
            mac_a_reg   <= mac_a_next;
            mac_b_reg   <= mac_b_next;
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (capture) begin
                y_full_reg <= mac_out;
                y_data_reg <= scaled;
            end
        end
    end

    // Delay line and coefficient bank; both cleared by reset so that taps
    // without a sample yet contribute zero.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NTAPS; i++) begin
            if (reset) begin
                delay_reg[i] <= '0;
                coef_reg[i]  <= '0;
            end else begin
                if (delay_we[i]) begin
                    delay_reg[i] <= s_data;
                end
                if (coef_wr_en[i]) begin
                    coef_reg[i] <= coef_data;
                end
            end
        end
    end

    fir_out_scale #(
        .SHIFT (SHIFT)
    ) u_scale (
        .acc (mac_out),
        .y   (scaled)
    );

    assign s_ready = (state_reg == IDLE);
    assign y_valid = (state_reg == OUT);
    assign mac_rst = mac_rst_reg;
    assign mac_a   = mac_a_reg;
    assign mac_b   = mac_b_reg;
    assign y_data  = y_data_reg;
    assign y_full  = y_full_reg;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: self-checking bench for fir_mac_sequencer with
// NTAPS=4, SHIFT=0. Contains a behavioural 3-cycle MAC and a reference FIR
// model (sample history queue + coefficient array).
// Build option FIR_SEQ_SAT_EN changes the expected y_data the same way it
// changes the design.
module tb_fir_mac_sequencer;

    localparam int NTAPS = 4;
    localparam int SHIFT = 0;
    localparam int AW    = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [35:0]   s_data = '0;
    logic          coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [17:0]   coef_data = '0;
    logic          mac_rst;
    logic [17:0]   mac_a;
    logic [35:0]   mac_b;
    logic          y_valid;
    logic          y_ready = 1'b0;
    logic [35:0]   y_data;
    logic [67:0]   y_full;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    // Behavioural MAC: product registered, one more pipeline stage, then
    // accumulate; mac_rst clears everything.
    logic signed [67:0] a_x, b_x, p1, p2, acc_m;
    assign a_x = $signed(mac_a);
    assign b_x = $signed(mac_b);

    always @(posedge clock) begin
        if (mac_rst) begin
            p1    <= '0;
            p2    <= '0;
            acc_m <= '0;
        end else begin
            p1    <= a_x * b_x;
            p2    <= p1;
            acc_m <= acc_m + p2;
        end
    end

    fir_mac_sequencer #(
        .NTAPS (NTAPS),
        .SHIFT (SHIFT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .mac_rst   (mac_rst),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_out   (acc_m),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .y_data    (y_data),
        .y_full    (y_full)
    );

    // Reference model state.
    logic signed [17:0] coef_m [NTAPS];
    logic signed [35:0] hist_q [$];

    task automatic model_clear();
        hist_q.delete();
        for (int i = 0; i < NTAPS; i++) coef_m[i] = '0;
    endtask

    task automatic model_expect(output logic [67:0] full_e, output logic [35:0] data_e);
        logic signed [67:0] sum, t, c, s, lim_hi, lim_lo;
        sum = '0;
        for (int k = 0; k < NTAPS; k++) begin
            if (k < hist_q.size()) begin
                c   = coef_m[k];
                s   = hist_q[hist_q.size() - 1 - k];
                sum = sum + c * s;
            end
        end
        full_e = sum;
        t      = sum >>> SHIFT;
        lim_hi = 68'sd34359738367;
        lim_lo = -lim_hi - 68'sd1;
`ifdef FIR_SEQ_SAT_EN
        if (t > lim_hi)      data_e = lim_hi[35:0];
        else if (t < lim_lo) data_e = lim_lo[35:0];
        else                 data_e = t[35:0];
`else
        data_e = t[35:0];
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_coef(input int a, input logic [17:0] v);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = v;
        tick();
        coef_we   = 1'b0;
        coef_m[a] = v;
    endtask

    // Presents a sample (optionally with a same-cycle coefficient write) and
    // returns one cycle after the accepting edge, i.e. in cycle 1.
    task automatic send(input logic [35:0] d, input bit with_coef,
                        input int ca, input logic [17:0] cd);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        if (with_coef) begin
            coef_we   = 1'b1;
            coef_addr = AW'(ca);
            coef_data = cd;
        end
        while (!s_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout s_ready=%0b required=1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        coef_we = 1'b0;
        hist_q.push_back($signed(d));
        if (hist_q.size() > NTAPS) void'(hist_q.pop_front());
        if (with_coef) coef_m[ca] = cd;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!y_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (!y_valid) begin
            checks++;
            failures++;
            $display("FAIL result_timeout y_valid=%0b required=1", y_valid);
        end
    endtask

    task automatic release_result(input int delay);
        repeat (delay) tick();
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (mac_rst !== 1'b1) begin failures++; $display("FAIL reset_mac_rst got=%0b exp=1", mac_rst); end
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_y_valid got=%0b exp=0", y_valid); end
        checks++; if (y_data !== 36'd0) begin failures++; $display("FAIL reset_y_data got=%0h exp=0", y_data); end
        checks++; if (y_full !== 68'd0) begin failures++; $display("FAIL reset_y_full got=%0h exp=0", y_full); end
        checks++; if (mac_a !== 18'd0) begin failures++; $display("FAIL reset_mac_a got=%0h exp=0", mac_a); end
        checks++; if (mac_b !== 36'd0) begin failures++; $display("FAIL reset_mac_b got=%0h exp=0", mac_b); end
        reset = 1'b0;
        tick();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL post_reset_s_ready got=%0b exp=1", s_ready); end
        checks++; if (mac_rst !== 1'b0) begin failures++; $display("FAIL post_reset_mac_rst got=%0b exp=0", mac_rst); end
        model_clear();
        $display("txn reset done");
    endtask

    task automatic test_impulse(input string tag);
        int          imp_exp [4] = '{1, 2, 3, 4};
        logic [35:0] imp_in  [4] = '{36'd1, 36'd0, 36'd0, 36'd0};
        int          lat;
        logic [67:0] ef;
        logic [35:0] ed;
        for (int i = 0; i < NTAPS; i++) write_coef(i, 18'(i + 1));
        for (int i = 0; i < 4; i++) begin
            send(imp_in[i], 1'b0, 0, '0);
            wait_result(lat);
            model_expect(ef, ed);
            if (i == 0) begin
                checks++;
                if (lat != NTAPS + 5) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, NTAPS + 5); end
            end
            checks++;
            if (y_full !== 68'(imp_exp[i])) begin failures++; $display("FAIL %s_full[%0d] got=%0h exp=%0h", tag, i, y_full, imp_exp[i]); end
            checks++;
            if (y_data !== ed) begin failures++; $display("FAIL %s_data[%0d] got=%0h exp=%0h", tag, i, y_data, ed); end
            $display("txn %s[%0d] lat=%0d y_full=%0h y_data=%0h", tag, i, lat, y_full, y_data);
            release_result(0);
        end
    endtask

    task automatic test_step();
        int          step_exp [5] = '{5, 15, 30, 50, 50};
        int          lat;
        logic [67:0] ef;
        logic [35:0] ed;
        for (int i = 0; i < 5; i++) begin
            send(36'd5, 1'b0, 0, '0);
            wait_result(lat);
            model_expect(ef, ed);
            checks++;
            if (y_full !== 68'(step_exp[i])) begin failures++; $display("FAIL step_full[%0d] got=%0h exp=%0h", i, y_full, step_exp[i]); end
            checks++;
            if (y_data !== ed) begin failures++; $display("FAIL step_data[%0d] got=%0h exp=%0h", i, y_data, ed); end
            $display("txn step[%0d] y_full=%0h y_data=%0h", i, y_full, y_data);
            release_result(0);
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [67:0] ef;
        logic [35:0] ed;
        logic [35:0] a, b;
        a = 36'($urandom_range(1, 1000));
        b = 36'($urandom_range(1, 1000));
        send(a, 1'b0, 0, '0);
        wait_result(lat);
        model_expect(ef, ed);
        s_valid = 1'b1;
        s_data  = b;
        for (int c = 0; c < 20; c++) begin
            checks++; if (y_valid !== 1'b1) begin failures++; $display("FAIL bp_y_valid[%0d] got=%0b exp=1", c, y_valid); end
            checks++; if (y_full !== ef) begin failures++; $display("FAIL bp_y_full[%0d] got=%0h exp=%0h", c, y_full, ef); end
            checks++; if (y_data !== ed) begin failures++; $display("FAIL bp_y_data[%0d] got=%0h exp=%0h", c, y_data, ed); end
            checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready[%0d] got=%0b exp=0", c, s_ready); end
            tick();
        end
        $display("txn backpressure held y_full=%0h", y_full);
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%0b exp=1", s_ready); end
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_after got=%0b exp=0", y_valid); end
        // s_valid is still high: the held sample is taken exactly once now.
        send(b, 1'b0, 0, '0);
        wait_result(lat);
        model_expect(ef, ed);
        checks++; if (y_full !== ef) begin failures++; $display("FAIL bp_next_full got=%0h exp=%0h", y_full, ef); end
        checks++; if (y_data !== ed) begin failures++; $display("FAIL bp_next_data got=%0h exp=%0h", y_data, ed); end
        $display("txn backpressure next y_full=%0h", y_full);
        release_result(0);
    endtask

    task automatic test_coef_busy();
        int          lat;
        logic [67:0] ef;
        logic [35:0] ed;
        for (int n = 0; n < 2; n++) begin
            send(36'($urandom_range(1, 5000)), 1'b0, 0, '0);
            tick();
            tick();
            coef_we   = 1'b1;
            coef_addr = AW'(n);
            coef_data = 18'd100;
            wait_result(lat);
            coef_we = 1'b0;
            model_expect(ef, ed);
            checks++; if (y_full !== ef) begin failures++; $display("FAIL coef_busy_full[%0d] got=%0h exp=%0h", n, y_full, ef); end
            checks++; if (y_data !== ed) begin failures++; $display("FAIL coef_busy_data[%0d] got=%0h exp=%0h", n, y_data, ed); end
            $display("txn coef_busy[%0d] y_full=%0h", n, y_full);
            release_result(1);
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [67:0] ef;
        logic [35:0] ed;
        logic [63:0] r;
        bit          wc;
        for (int i = 0; i < NTAPS; i++) write_coef(i, 18'($urandom));
        for (int n = 0; n < 24; n++) begin
            r  = {$urandom(), $urandom()};
            wc = ($urandom_range(0, 2) == 0);
            send(r[35:0], wc, int'($urandom_range(0, NTAPS - 1)), 18'($urandom));
            wait_result(lat);
            model_expect(ef, ed);
            checks++; if (y_full !== ef) begin failures++; $display("FAIL rand_full[%0d] got=%0h exp=%0h", n, y_full, ef); end
            checks++; if (y_data !== ed) begin failures++; $display("FAIL rand_data[%0d] got=%0h exp=%0h", n, y_data, ed); end
            $display("txn random[%0d] coefwr=%0b y_full=%0h y_data=%0h", n, wc, y_full, y_data);
            release_result(int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_saturation();
        int                 lat;
        logic [67:0]        ef;
        logic [35:0]        ed;
        logic signed [67:0] big;
        logic [35:0]        samp [2] = '{36'h7_FFFF_FFFF, 36'h8_0000_0000};
        for (int i = 0; i < NTAPS; i++) write_coef(i, 18'h1_FFFF);
        big = 68'sd4 * 68'sd131071 * 68'sd34359738367;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NTAPS; i++) begin
                send(samp[p], 1'b0, 0, '0);
                wait_result(lat);
                model_expect(ef, ed);
                checks++; if (y_full !== ef) begin failures++; $display("FAIL sat_full[%0d][%0d] got=%0h exp=%0h", p, i, y_full, ef); end
                checks++; if (y_data !== ed) begin failures++; $display("FAIL sat_data[%0d][%0d] got=%0h exp=%0h", p, i, y_data, ed); end
                if (p == 0 && i == NTAPS - 1) begin
                    checks++; if (y_full !== big) begin failures++; $display("FAIL sat_full_const got=%0h exp=%0h", y_full, big); end
`ifdef FIR_SEQ_SAT_EN
                    checks++; if (y_data !== 36'h7_FFFF_FFFF) begin failures++; $display("FAIL sat_data_const got=%0h exp=7ffffffff", y_data); end
`else
                    checks++; if (y_data !== big[35:0]) begin failures++; $display("FAIL sat_data_const got=%0h exp=%0h", y_data, big[35:0]); end
`endif
                end
                $display("txn saturation[%0d][%0d] y_full=%0h y_data=%0h", p, i, y_full, y_data);
                release_result(0);
            end
        end
    endtask

    task automatic test_reset_drain();
        for (int i = 0; i < NTAPS; i++) write_coef(i, 18'(i + 7));
        send(36'($urandom_range(1, 100)), 1'b0, 0, '0);
        // Now in cycle 1; advance to the middle of DRAIN (cycle NTAPS+3).
        repeat (NTAPS + 2) tick();
        reset = 1'b1;
        tick();
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL rst_drain_y_valid got=%0b exp=0", y_valid); end
        checks++; if (mac_rst !== 1'b1) begin failures++; $display("FAIL rst_drain_mac_rst got=%0b exp=1", mac_rst); end
        checks++; if (mac_a !== 18'd0) begin failures++; $display("FAIL rst_drain_mac_a got=%0h exp=0", mac_a); end
        tick();
        reset = 1'b0;
        model_clear();
        tick();
        for (int c = 0; c < 12; c++) begin
            checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL rst_drain_stale[%0d] got=%0b exp=0", c, y_valid); end
            tick();
        end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_drain_s_ready got=%0b exp=1", s_ready); end
        $display("txn reset_in_drain done");
        test_impulse("post_reset_impulse");
    endtask

    initial begin
        test_reset();
        test_impulse("impulse");
        test_step();
        test_backpressure();
        test_coef_busy();
        test_random();
        test_saturation();
        test_reset_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
